// File: rtl/svc_axi_burst_initiator.sv
// svc_axi_burst_initiator: single-outstanding AXI4 manager turning client burst commands into AW/W/B or AR/R transactions.
// Optional `SVC_AXI_BURST_INIT_4K_CHECK_EN rejects bursts crossing a 4KB boundary without touching the AXI port.
module svc_axi_burst_initiator #(
  parameter int AXI_ADDR_WIDTH = 20,
  parameter int AXI_DATA_WIDTH = 16,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH/8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_cmd_valid,
  output logic                      o_cmd_ready,
  input  logic                      i_cmd_wr_en,
  input  logic [AXI_ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [7:0]                i_cmd_len,
  input  logic [AXI_ID_WIDTH-1:0]   i_cmd_id,
  input  logic                      i_wr_valid,
  output logic                      o_wr_ready,
  input  logic [AXI_DATA_WIDTH-1:0] i_wr_data,
  input  logic [AXI_STRB_WIDTH-1:0] i_wr_strb,
  output logic                      o_rd_valid,
  input  logic                      i_rd_ready,
  output logic [AXI_DATA_WIDTH-1:0] o_rd_data,
  output logic [AXI_ID_WIDTH-1:0]   o_rd_id,
  output logic [1:0]                o_rd_resp,
  output logic                      o_rd_last,
  output logic                      o_wr_done_valid,
  input  logic                      i_wr_done_ready,
  output logic [AXI_ID_WIDTH-1:0]   o_wr_done_id,
  output logic [1:0]                o_wr_done_resp,
  output logic                      o_m_axi_awvalid,
  input  logic                      i_m_axi_awready,
  output logic [AXI_ADDR_WIDTH-1:0] o_m_axi_awaddr,
  output logic [7:0]                o_m_axi_awlen,
  output logic [2:0]                o_m_axi_awsize,
  output logic [1:0]                o_m_axi_awburst,
  output logic [AXI_ID_WIDTH-1:0]   o_m_axi_awid,
  output logic                      o_m_axi_awlock,
  output logic [3:0]                o_m_axi_awcache,
  output logic [2:0]                o_m_axi_awprot,
  output logic                      o_m_axi_wvalid,
  input  logic                      i_m_axi_wready,
  output logic [AXI_DATA_WIDTH-1:0] o_m_axi_wdata,
  output logic [AXI_STRB_WIDTH-1:0] o_m_axi_wstrb,
  output logic                      o_m_axi_wlast,
  input  logic                      i_m_axi_bvalid,
  output logic                      o_m_axi_bready,
  input  logic [AXI_ID_WIDTH-1:0]   i_m_axi_bid,
  input  logic [1:0]                i_m_axi_bresp,
  output logic                      o_m_axi_arvalid,
  input  logic                      i_m_axi_arready,
  output logic [AXI_ADDR_WIDTH-1:0] o_m_axi_araddr,
  output logic [7:0]                o_m_axi_arlen,
  output logic [2:0]                o_m_axi_arsize,
  output logic [1:0]                o_m_axi_arburst,
  output logic [AXI_ID_WIDTH-1:0]   o_m_axi_arid,
  output logic                      o_m_axi_arlock,
  output logic [3:0]                o_m_axi_arcache,
  output logic [2:0]                o_m_axi_arprot,
  input  logic                      i_m_axi_rvalid,
  output logic                      o_m_axi_rready,
  input  logic [AXI_ID_WIDTH-1:0]   i_m_axi_rid,
  input  logic [AXI_DATA_WIDTH-1:0] i_m_axi_rdata,
  input  logic [1:0]                i_m_axi_rresp,
  input  logic                      i_m_axi_rlast
);
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_B, S_AR, S_R} state_t;
  state_t r_state, w_next;
  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [7:0] r_len, r_beat;
  logic [AXI_ID_WIDTH-1:0] r_id;
  logic r_aw_done, r_w_done, r_err;
  logic w_cmd_fire, w_cross, w_aw_fire, w_w_fire, w_w_last, w_aw_ok, w_w_ok;
  assign w_cmd_fire = i_cmd_valid && o_cmd_ready;
`ifdef SVC_AXI_BURST_INIT_4K_CHECK_EN
  logic [31:0] w_end;
  assign w_end   = 32'(i_cmd_addr[11:0]) + (32'(i_cmd_len) + 32'd1) * 32'(AXI_STRB_WIDTH);
  assign w_cross = w_end > 32'd4096;
`else
  assign w_cross = 1'b0;
`endif
  assign o_cmd_ready = r_state == S_IDLE;
  assign o_m_axi_awaddr  = r_addr;
  assign o_m_axi_awlen   = r_len;
  assign o_m_axi_awid    = r_id;
  assign o_m_axi_awsize  = 3'($clog2(AXI_STRB_WIDTH));
  assign o_m_axi_awburst = 2'b01;
  assign o_m_axi_awlock  = 1'b0;
  assign o_m_axi_awcache = 4'b0011;
  assign o_m_axi_awprot  = 3'b000;
  assign o_m_axi_araddr  = r_addr;
  assign o_m_axi_arlen   = r_len;
  assign o_m_axi_arid    = r_id;
  assign o_m_axi_arsize  = 3'($clog2(AXI_STRB_WIDTH));
  assign o_m_axi_arburst = 2'b01;
  assign o_m_axi_arlock  = 1'b0;
  assign o_m_axi_arcache = 4'b0011;
  assign o_m_axi_arprot  = 3'b000;
  // A rejected write still drains the client's beats but never reaches the W channel.
  assign o_m_axi_awvalid = r_state == S_WRITE && !r_aw_done && !r_err;
  assign o_wr_ready      = r_state == S_WRITE && !r_w_done && (r_err || i_m_axi_wready);
  assign o_m_axi_wvalid  = r_state == S_WRITE && !r_w_done && !r_err && i_wr_valid;
  assign o_m_axi_wdata   = i_wr_data;
  assign o_m_axi_wstrb   = i_wr_strb;
  assign w_w_last        = r_beat == r_len;
  assign o_m_axi_wlast   = w_w_last;
  assign w_aw_fire = o_m_axi_awvalid && i_m_axi_awready;
  assign w_w_fire  = i_wr_valid && o_wr_ready;
  assign w_aw_ok   = r_aw_done || w_aw_fire || r_err;
  assign w_w_ok    = r_w_done || (w_w_fire && w_w_last);
  assign o_m_axi_bready  = r_state == S_B && !r_err && i_wr_done_ready;
  assign o_wr_done_valid = r_state == S_B && (r_err || i_m_axi_bvalid);
  assign o_wr_done_id    = r_err ? r_id : i_m_axi_bid;
  assign o_wr_done_resp  = r_err ? 2'b10 : i_m_axi_bresp;
  assign o_m_axi_arvalid = r_state == S_AR;
  assign o_m_axi_rready  = r_state == S_R && !r_err && i_rd_ready;
  assign o_rd_valid      = r_state == S_R && (r_err || i_m_axi_rvalid);
  assign o_rd_data       = r_err ? '0 : i_m_axi_rdata;
  assign o_rd_id         = r_err ? r_id : i_m_axi_rid;
  assign o_rd_resp       = r_err ? 2'b10 : i_m_axi_rresp;
  assign o_rd_last       = r_err || i_m_axi_rlast;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = !i_cmd_valid ? S_IDLE : i_cmd_wr_en ? S_WRITE : w_cross ? S_R : S_AR;
      S_WRITE: w_next = (w_aw_ok && w_w_ok) ? S_B : S_WRITE;
      S_B:     w_next = (o_wr_done_valid && i_wr_done_ready) ? S_IDLE : S_B;
      S_AR:    w_next = i_m_axi_arready ? S_R : S_AR;
      S_R:     w_next = (o_rd_valid && i_rd_ready && o_rd_last) ? S_IDLE : S_R;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_len     <= '0;
      r_id      <= '0;
      r_beat    <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_cmd_fire) begin
        r_addr    <= i_cmd_addr;
        r_len     <= i_cmd_len;
        r_id      <= i_cmd_id;
        r_beat    <= '0;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        r_err     <= w_cross;
      end else begin
        if (w_w_fire && !w_w_last) r_beat <= r_beat + 8'd1;
        if (w_w_fire && w_w_last) r_w_done <= 1'b1;
        if (w_aw_fire) r_aw_done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_svc_axi_burst_initiator.sv
// tb_svc_axi_burst_initiator: table-driven bench with a small AXI subordinate model and a beat scoreboard.
module tb_svc_axi_burst_initiator;
  localparam int AW = 20, DW = 16, IW = 4, SW = 2;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic cmd_valid = 0, cmd_ready, cmd_wr_en = 0;
  logic [AW-1:0] cmd_addr = '0;
  logic [7:0] cmd_len = '0;
  logic [IW-1:0] cmd_id = '0;
  logic wr_valid = 0, wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic [SW-1:0] wr_strb = '0;
  logic rd_valid, rd_ready = 0, rd_last;
  logic [DW-1:0] rd_data;
  logic [IW-1:0] rd_id;
  logic [1:0] rd_resp;
  logic wr_done_valid, wr_done_ready = 0;
  logic [IW-1:0] wr_done_id;
  logic [1:0] wr_done_resp;
  logic awvalid, awready = 0, awlock, arvalid, arready = 0, arlock;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize, awprot, arprot;
  logic [1:0] awburst, arburst;
  logic [IW-1:0] awid, arid;
  logic [3:0] awcache, arcache;
  logic wvalid, wready = 0, wlast;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic bvalid = 0, bready;
  logic [IW-1:0] bid = '0;
  logic [1:0] bresp = '0;
  logic rvalid = 0, rready, rlast = 0;
  logic [IW-1:0] rid = '0;
  logic [DW-1:0] rdata = '0;
  logic [1:0] rresp = '0;

  svc_axi_burst_initiator dut (
    .clk(clk), .rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_wr_en(cmd_wr_en),
    .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len), .i_cmd_id(cmd_id),
    .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_data(wr_data), .i_wr_strb(wr_strb),
    .o_rd_valid(rd_valid), .i_rd_ready(rd_ready), .o_rd_data(rd_data), .o_rd_id(rd_id),
    .o_rd_resp(rd_resp), .o_rd_last(rd_last),
    .o_wr_done_valid(wr_done_valid), .i_wr_done_ready(wr_done_ready),
    .o_wr_done_id(wr_done_id), .o_wr_done_resp(wr_done_resp),
    .o_m_axi_awvalid(awvalid), .i_m_axi_awready(awready), .o_m_axi_awaddr(awaddr),
    .o_m_axi_awlen(awlen), .o_m_axi_awsize(awsize), .o_m_axi_awburst(awburst),
    .o_m_axi_awid(awid), .o_m_axi_awlock(awlock), .o_m_axi_awcache(awcache), .o_m_axi_awprot(awprot),
    .o_m_axi_wvalid(wvalid), .i_m_axi_wready(wready), .o_m_axi_wdata(wdata),
    .o_m_axi_wstrb(wstrb), .o_m_axi_wlast(wlast),
    .i_m_axi_bvalid(bvalid), .o_m_axi_bready(bready), .i_m_axi_bid(bid), .i_m_axi_bresp(bresp),
    .o_m_axi_arvalid(arvalid), .i_m_axi_arready(arready), .o_m_axi_araddr(araddr),
    .o_m_axi_arlen(arlen), .o_m_axi_arsize(arsize), .o_m_axi_arburst(arburst),
    .o_m_axi_arid(arid), .o_m_axi_arlock(arlock), .o_m_axi_arcache(arcache), .o_m_axi_arprot(arprot),
    .i_m_axi_rvalid(rvalid), .o_m_axi_rready(rready), .i_m_axi_rid(rid),
    .i_m_axi_rdata(rdata), .i_m_axi_rresp(rresp), .i_m_axi_rlast(rlast)
  );

  typedef struct {
    bit wr; logic [AW-1:0] addr; logic [7:0] len; logic [IW-1:0] id;
    int dly; int err_beat; bit tgl; logic [SW-1:0] strb; bit early_b; logic [1:0] e_resp;
  } vec_t;
  typedef struct { logic [DW-1:0] data; logic [1:0] resp; logic last; } beat_t;
  vec_t vecs[7];
  beat_t sb[$];
  int n_cmp = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  task automatic pop_beat(output beat_t e);
    if (sb.size() == 0) begin
      timeout("scoreboard_underflow");
      e = '{'0, 2'b00, 1'b0};
    end else e = sb.pop_front();
  endtask

  task automatic send_cmd(input bit wr, input logic [AW-1:0] a, input logic [7:0] l, input logic [IW-1:0] id);
    @(negedge clk);
    cmd_valid = 1; cmd_wr_en = wr; cmd_addr = a; cmd_len = l; cmd_id = id;
    #1 chk("cmd_ready_idle", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 0;
  endtask

  task automatic do_write(input vec_t v);
    int beat = 0, cyc = 0;
    bit aw_seen = 0;
    beat_t e;
    for (int k = 0; k <= int'(v.len); k++) sb.push_back('{{v.id, 12'(k + 1)}, 2'b00, k == int'(v.len)});
    send_cmd(1, v.addr, v.len, v.id);
    while ((!aw_seen || beat <= int'(v.len)) && cyc < 300) begin
      @(negedge clk);
      awready = cyc >= v.dly; wready = 1; wr_valid = 1;
      wr_data = {v.id, 12'(beat + 1)}; wr_strb = v.strb;
      bvalid = v.early_b; bid = v.id; bresp = v.e_resp; wr_done_ready = 1;
      #1;
      chk("awvalid_hold", awvalid, !aw_seen);
      chk("wvalid_gate", wvalid, beat <= int'(v.len));
      chk("wr_ready_gate", wr_ready, beat <= int'(v.len));
      chk("bready_in_write", bready, 0);
      chk("wr_done_in_write", wr_done_valid, 0);
      if (awvalid && awready) begin
        chk("awaddr", awaddr, v.addr);
        chk("awlen", awlen, v.len);
        chk("awsize", awsize, 1);
        chk("awburst", awburst, 1);
        chk("awid", awid, v.id);
        aw_seen = 1;
      end
      if (wvalid && wready) begin
        pop_beat(e);
        chk("wdata", wdata, e.data);
        chk("wlast", wlast, e.last);
        chk("wstrb", wstrb, v.strb);
        beat++;
      end
      cyc++;
    end
    if (cyc >= 300) timeout("write_phase");
    @(negedge clk);
    wr_valid = 0; awready = 0; bvalid = 1; bid = v.id; bresp = v.e_resp; wr_done_ready = 1;
    #1;
    chk("cmd_ready_busy", cmd_ready, 0);
    chk("wr_done_valid", wr_done_valid, 1);
    chk("wr_done_id", wr_done_id, v.id);
    chk("wr_done_resp", wr_done_resp, v.e_resp);
    chk("bready", bready, 1);
    @(negedge clk);
    bvalid = 0; wr_done_ready = 0;
    #1 chk("cmd_ready_after_b", cmd_ready, 1);
  endtask

  task automatic do_read(input vec_t v);
    int k = 0, cyc = 0;
    bit ar_done = 0;
    beat_t e;
    for (int j = 0; j <= int'(v.len); j++)
      sb.push_back('{{v.id, 12'(j + 1)}, (j == v.err_beat) ? 2'b10 : 2'b00, j == int'(v.len)});
    send_cmd(0, v.addr, v.len, v.id);
    while (!ar_done && cyc < 300) begin
      @(negedge clk);
      arready = cyc >= v.dly;
      #1 chk("arvalid_hold", arvalid, 1);
      chk("rready_in_ar", rready, 0);
      if (arready) begin
        chk("araddr", araddr, v.addr);
        chk("arlen", arlen, v.len);
        chk("arsize", arsize, 1);
        chk("arburst", arburst, 1);
        chk("arid", arid, v.id);
        ar_done = 1;
      end
      cyc++;
    end
    if (!ar_done) timeout("ar_phase");
    cyc = 0;
    while (k <= int'(v.len) && cyc < 300) begin
      @(negedge clk);
      arready = 0; rvalid = 1; rdata = {v.id, 12'(k + 1)}; rid = v.id;
      rresp = (k == v.err_beat) ? 2'b10 : 2'b00; rlast = k == int'(v.len);
      rd_ready = v.tgl ? ((cyc % 2) == 0) : 1'b1;
      #1;
      chk("arvalid_in_r", arvalid, 0);
      chk("rready", rready, rd_ready);
      chk("rd_valid", rd_valid, 1);
      if (rd_valid && rd_ready) begin
        pop_beat(e);
        chk("rd_data", rd_data, e.data);
        chk("rd_resp", rd_resp, e.resp);
        chk("rd_last", rd_last, e.last);
        chk("rd_id", rd_id, v.id);
      end
      if (rvalid && rready) k++;
      cyc++;
    end
    if (cyc >= 300) timeout("r_phase");
    @(negedge clk);
    rvalid = 0; rlast = 0; rd_ready = 0;
    #1 chk("cmd_ready_after_r", cmd_ready, 1);
    chk("sb_empty", sb.size(), 0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 20'h100, 8'd3, 4'd1, 2, -1, 1'b0, 2'b11, 1'b0, 2'b00};
    vecs[1] = '{1'b1, 20'h100, 8'd3, 4'd2, 6, -1, 1'b0, 2'b11, 1'b1, 2'b00};
    vecs[2] = '{1'b0, 20'h100, 8'd3, 4'd3, 1, -1, 1'b1, 2'b11, 1'b0, 2'b00};
    vecs[3] = '{1'b0, 20'h200, 8'd3, 4'd4, 0, 1, 1'b0, 2'b11, 1'b0, 2'b00};
    vecs[4] = '{1'b1, 20'h040, 8'd0, 4'd5, 0, -1, 1'b0, 2'b01, 1'b0, 2'b10};
    vecs[5] = '{1'b0, 20'h010, 8'd7, 4'd6, 3, -1, 1'b1, 2'b11, 1'b0, 2'b00};
    vecs[6] = '{1'b0, 20'h300, 8'd1, 4'd8, 0, -1, 1'b0, 2'b11, 1'b0, 2'b00};
    repeat (2) @(negedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_rready", rready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_wr_done_valid", wr_done_valid, 0);
    @(negedge clk) rst = 0;
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].wr) do_write(vecs[i]);
      else do_read(vecs[i]);
    end
    // Reset in the middle of a write burst after two beats.
    send_cmd(1, 20'h300, 8'd3, 4'd7);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      awready = 0; wready = 1; wr_valid = 1; wr_data = 16'(k + 1); wr_strb = 2'b11;
    end
    @(negedge clk);
    bvalid = 1; wr_done_ready = 1;
    #1;
    chk("pre_rst_awvalid", awvalid, 1);
    chk("pre_rst_wvalid", wvalid, 1);
    rst = 1;
    #1;
    chk("midrst_awvalid", awvalid, 0);
    chk("midrst_wvalid", wvalid, 0);
    chk("midrst_bready", bready, 0);
    chk("midrst_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    rst = 0; wr_valid = 0; bvalid = 0; wr_done_ready = 0;
    #1 chk("post_rst_cmd_ready", cmd_ready, 1);
    do_read(vecs[6]);
`ifdef SVC_AXI_BURST_INIT_4K_CHECK_EN
    send_cmd(0, 20'hFFE, 8'd1, 4'd9);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      rd_ready = c == 2; rvalid = 0;
      #1;
      chk("4k_arvalid", arvalid, 0);
      chk("4k_rd_valid", rd_valid, 1);
      chk("4k_rd_data", rd_data, 0);
      chk("4k_rd_resp", rd_resp, 2'b10);
      chk("4k_rd_last", rd_last, 1);
      chk("4k_rd_id", rd_id, 9);
    end
    @(negedge clk);
    rd_ready = 0;
    #1 chk("4k_rd_cmd_ready", cmd_ready, 1);
    send_cmd(1, 20'hFFE, 8'd1, 4'd10);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      wr_valid = 1; awready = 1; wready = 0;
      #1;
      chk("4k_wr_ready", wr_ready, 1);
      chk("4k_awvalid", awvalid, 0);
      chk("4k_wvalid", wvalid, 0);
    end
    @(negedge clk);
    wr_valid = 0; awready = 0; wr_done_ready = 1;
    #1;
    chk("4k_wr_done_valid", wr_done_valid, 1);
    chk("4k_wr_done_resp", wr_done_resp, 2'b10);
    chk("4k_wr_done_id", wr_done_id, 10);
    chk("4k_bready", bready, 0);
    @(negedge clk);
    wr_done_ready = 0;
    #1 chk("4k_wr_cmd_ready", cmd_ready, 1);
`else
    begin
      vec_t v4k;
      v4k = '{1'b0, 20'hFFE, 8'd1, 4'd9, 0, -1, 1'b0, 2'b11, 1'b0, 2'b00};
      do_read(v4k);
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
